// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and
// frame defaults used by the receiver and its sibling blocks.
package uart_pkg;

    localparam int OVERSAMPLE    = 16;
    localparam int MID_START     = 7;
    localparam int DEF_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver driven by a 16x baud tick; emits a one-cycle done pulse per
// good frame and a one-cycle frame-error pulse when the stop bit is sampled low.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int SB_TICKS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_rx,
    input  logic                 i_tick,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err
);

    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 rx_meta_q, rx_s_q;
    rx_state_e            state_q, state_d;
    logic [4:0]           s_q, s_d;
    logic [NW-1:0]        n_q, n_d;
    logic [DATA_BITS-1:0] b_q, b_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= ST_IDLE;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (s_q == 5'(MID_START)) begin
                        s_d = '0;
                        n_d = '0;
                        // A line back high at mid start bit was only a glitch.
                        state_d = rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (s_q == 5'(OVERSAMPLE - 1)) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[DATA_BITS-1:1]};
                        if (n_q == NW'(DATA_BITS - 1)) state_d = ST_STOP;
                        else                           n_d = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (s_q == 5'(SB_TICKS - 1)) begin
                        if (rx_s_q) begin
                            data_d  = b_q;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: frames are queued on a scoreboard as
// they are driven and matched against done / frame-error pulses.
module tb_uart_rx_oversampled;

    localparam int TICK_DIV = 8;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_rx;
    logic       i_tick = 1'b0;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;

    int         errors = 0;
    int         checks = 0;
    exp_t       exp_q[$];
    logic [7:0] last_good = 8'h00;

    logic       consumer_en = 1'b0;
    int         consumer_idx = 0;
    logic [7:0] op_a, op_b, opcode;
    logic       tx_start = 1'b0;

    uart_rx_oversampled #(.DATA_BITS(8), .SB_TICKS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx        (i_rx),
        .i_tick      (i_tick),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt    = (cnt == TICK_DIV - 1) ? 0 : cnt + 1;
            i_tick = (cnt == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor plus a small model of the downstream operand loader.
    always @(negedge clk) begin
        if (o_rx_done || o_frame_err) begin
            check("pulse_exclusive", {31'd0, o_rx_done & o_frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, o_rx_done, o_frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, o_frame_err}, {31'd0, e.is_err});
                check("rx_data", {24'd0, o_data}, {24'd0, e.data});
            end
            if (o_rx_done && consumer_en) begin
                case (consumer_idx)
                    0:       op_a = o_data;
                    1:       op_b = o_data;
                    default: begin opcode = o_data; tx_start = 1'b1; end
                endcase
                consumer_idx++;
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!i_tick) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_ticks);
        exp_t e;
        e.is_err = ~stop_bit;
        e.data   = stop_bit ? d : last_good;
        if (stop_bit) last_good = d;
        exp_q.push_back(e);
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            wait_ticks(16);
        end
        i_rx = stop_bit;
        wait_ticks(stop_ticks);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        i_rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", {24'd0, o_data}, 32'd0);
        check("reset_done", {31'd0, o_rx_done}, 32'd0);
        check("reset_ferr", {31'd0, o_frame_err}, 32'd0);
        reset = 1'b0;
        wait_ticks(20);

        // Ideal frame.
        send_frame(8'hA5, 1'b1, 16);
        i_rx = 1'b1;
        wait_ticks(8);
        drain("a5_received");
        check("a5_held", {24'd0, o_data}, 32'h0000_00A5);

        // Start-bit glitch: nothing queued, so any pulse is flagged by the monitor.
        i_rx = 1'b0;
        wait_ticks(4);
        i_rx = 1'b1;
        wait_ticks(40);
        check("glitch_data", {24'd0, o_data}, 32'h0000_00A5);

        // Bad stop bit followed by a long break, then a good frame.
        send_frame(8'h3C, 1'b0, 16);
        wait_ticks(40);
        drain("ferr_seen");
        check("ferr_data_kept", {24'd0, o_data}, 32'h0000_00A5);
        i_rx = 1'b1;
        wait_ticks(40);
        check("break_single_ferr", 32'(exp_q.size()), 32'd0);
        send_frame(8'h81, 1'b1, 16);
        i_rx = 1'b1;
        wait_ticks(8);
        drain("after_break_81");

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 16);
        send_frame(8'hFF, 1'b1, 16);
        send_frame(8'h55, 1'b1, 16);
        i_rx = 1'b1;
        wait_ticks(8);
        drain("b2b_frames");
        check("b2b_last", {24'd0, o_data}, 32'h0000_0055);

        // Reset in the middle of data bit 4 of 0x12: frame abandoned, no pulse.
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            i_rx = (i == 1);
            wait_ticks(16);
        end
        i_rx = 1'b1;
        wait_ticks(8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_good = 8'h00;
        check("midreset_data", {24'd0, o_data}, 32'd0);
        check("midreset_done", {31'd0, o_rx_done}, 32'd0);
        check("midreset_ferr", {31'd0, o_frame_err}, 32'd0);
        check("midreset_state", {29'd0, dut.state_q}, 32'd0);
        wait_ticks(40);
        check("midreset_quiet", {24'd0, o_data}, 32'd0);
        send_frame(8'h3C, 1'b1, 16);
        i_rx = 1'b1;
        wait_ticks(8);
        drain("post_reset_3c");

        // Operand A, operand B, opcode into the downstream loader model.
        consumer_en = 1'b1;
        send_frame(8'h05, 1'b1, 16);
        send_frame(8'h03, 1'b1, 16);
        send_frame(8'h20, 1'b1, 16);
        i_rx = 1'b1;
        wait_ticks(8);
        drain("alu_seq");
        check("alu_count", 32'(consumer_idx), 32'd3);
        check("alu_a", {24'd0, op_a}, 32'h05);
        check("alu_b", {24'd0, op_b}, 32'h03);
        check("alu_op", {24'd0, opcode}, 32'h20);
        check("alu_tx_start", {31'd0, tx_start}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
